// File: rtl/ds_feed_ctrl_if.sv
// Purpose : sample stream into the DeltaSigma feed sequencer and the held sample out of it.
// Latency : none; signal bundle only.
// Backpressure: in_valid/in_ready handshake on the input side; the modulator side never stalls.
// Ports   : in_data/in_valid (source->ctrl), in_ready (ctrl->source),
//           mod_data/mod_tick/mod_clr (ctrl->modulator).
interface ds_feed_ctrl_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mod_data;
    logic              mod_tick;
    logic              mod_clr;

    // master: the interpolator/testbench side driving samples in
    modport master (
        output in_data, in_valid,
        input  in_ready, mod_data, mod_tick, mod_clr
    );

    // slave: the sequencer itself
    modport slave (
        input  in_data, in_valid,
        output in_ready, mod_data, mod_tick, mod_clr
    );
endinterface

// File: rtl/ds_feed_ctrl.sv
// Purpose : buffers samples and holds each on mod_data for OSR clocks; keeps modulator cleared until primed.
// Latency : first sample on mod_data 1 clk after RUN entry, then one new sample every OSR clks.
// Backpressure: in_ready drops when the FIFO is full or enable is low; an empty pop mutes and flags underflow.
// Ports   : clk, reset (async, active-high), enable, clear_flags,
//           bus (slave: in_data/in_valid/in_ready, mod_data/mod_tick/mod_clr),
//           fifo_level (occupancy), underflow (sticky).
module ds_feed_ctrl #(
    parameter int DATA_W     = 14,
    parameter int OSR        = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PRIME_LVL  = 2,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_flags,
    ds_feed_ctrl_if.slave     bus,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              underflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(OSR);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [CNT_W-1:0]   osr_cnt_q;
    logic [DATA_W-1:0]  mod_data_q;
    logic               mod_tick_q;
    logic               underflow_q;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];

    logic full, empty, in_ready, push, pop, flush, mod_clr;

    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    // Gating with reset keeps in_ready low while reset is held, even if enable is already up.
    assign in_ready = enable & ~full & ~reset;
    assign push     = bus.in_valid & in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_PRIME;
            S_PRIME: begin
                if (!enable)                             state_d = S_IDLE;
                else if (level_q >= LVL_W'(PRIME_LVL))   state_d = S_RUN;
            end
            S_RUN:   if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mod_clr = (state_q != S_RUN);
        pop     = (state_q == S_RUN) && enable && (osr_cnt_q == '0);
        // enable low always means IDLE next clk, so the datapath is flushed on the same edge.
        flush   = ~enable;
    end

    // ---------------- FIFO storage (no reset needed; guarded by level) ----------------
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.in_data;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            osr_cnt_q  <= '0;
            mod_data_q <= '0;
            mod_tick_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            osr_cnt_q  <= '0;
            mod_data_q <= '0;
            mod_tick_q <= 1'b0;
        end else begin
            if (push)          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            case ({push, pop && !empty})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase

            if (state_q == S_RUN)
                osr_cnt_q <= (osr_cnt_q == CNT_W'(OSR - 1)) ? '0 : osr_cnt_q + CNT_W'(1);
            else
                osr_cnt_q <= '0;

            mod_tick_q <= pop;
            // An empty pop mutes the modulator rather than repeating stale data.
            if (pop) mod_data_q <= empty ? '0 : mem[rd_ptr_q];
        end
    end

    // Sticky underflow survives flushes; a new empty pop beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               underflow_q <= 1'b0;
        else if (pop && empty)   underflow_q <= 1'b1;
        else if (clear_flags)    underflow_q <= 1'b0;
    end

    assign bus.in_ready = in_ready;
    assign bus.mod_data = mod_data_q;
    assign bus.mod_tick = mod_tick_q;
    assign bus.mod_clr  = mod_clr;
    assign fifo_level   = level_q;
    assign underflow    = underflow_q;
endmodule
